fetch_decode_queue: RTL and testbench
=====================================

# fetch_decode_queue

Instruction queue between fetch and decode. It buffers fetched {pc, instr} pairs in a small circular FIFO, decoupling fetch from decode stalls, and presents the oldest entry to decode (opcode/immediate extraction) with a valid/ready handshake. A flush input discards all buffered instructions on redirect (branch/jump mispredict), so decode never sees wrong-path instructions.

## Interface
- DEPTH, 4, number of entries; power of two, 2..16
- PC_W, 32, program-counter width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  discard all entries this cycle
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  queue can accept this cycle
- in_pc  input  PC_W  PC of incoming instruction
- in_instr  input  32  incoming instruction word
- out_valid  output  1  head entry presented to decode
- out_ready  input  1  decode consumes head this cycle
- out_pc  output  PC_W  PC of head entry
- out_instr  output  32  instruction word of head entry
- count  output  $clog2(DEPTH)+1  number of occupied entries

## Operation
- Storage: DEPTH entries of {pc, instr}; write pointer, read pointer ($clog2(DEPTH) bits, wrap naturally at DEPTH), registered count.
- Push: in_valid && in_ready && !flush → write entry at wr_ptr, wr_ptr+1.
- Pop: out_valid && out_ready → rd_ptr+1.
- Push and pop in the same cycle: both pointers advance, count unchanged.
- count next = count + push − pop; never exceeds DEPTH, never below 0.
- in_ready = (count != DEPTH) && !flush. Full queue does not accept even if a pop occurs the same cycle (no pass-through of full-to-full).
- out_valid = (count != 0) && !flush.
- out_pc/out_instr: head entry when out_valid=1; when out_valid=0, out_pc=0 and out_instr=32'h0000_0013 (addi x0,x0,0 NOP), so downstream combinational decode sees a legal NOP.
- Flush: at the next edge wr_ptr, rd_ptr, count ← 0; any in_valid and out_ready that cycle are ignored (no push, no pop). Entry contents need not be cleared.
- No bypass: an instruction pushed at edge N is first visible on out_* after edge N (i.e. in cycle N+1); an empty queue never forwards in_* to out_* combinationally.
- Storage array is not reset; only pointers and count are.

## Timing
- Reset (rst_n=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0 immediately; hence out_valid=0, out_pc=0, out_instr=32'h0000_0013, in_ready=1 (while flush=0).
- Reset deasserted mid-stream: queue empty, first push accepted on the first rising edge with rst_n=1.
- Latency in→out: 1 cycle. Throughput: 1 instruction/cycle sustained when neither full nor empty-starved.
- in_ready, out_valid depend combinationally only on registered count and flush; no combinational path from in_valid to in_ready or out_ready to out_valid.
- Data ordering: strict FIFO across pointer wrap.
- Full (count=DEPTH): in_ready=0; fetch must hold in_pc/in_instr stable until accepted.
- Empty (count=0): out_valid=0; out_ready ignored.
- Flush with simultaneous push and pop: both dropped; count=0 next cycle.

## Test plan
- Reset: assert rst_n=0 with queue holding 3 entries → count=0, out_valid=0, out_instr=32'h00000013, in_ready=1 without a clock edge.
- Fill/drain, DEPTH=4, out_ready=0: push pc 0x00,0x04,0x08,0x0C (instr 0x00500093..) → count=4, in_ready=0, 5th push (pc 0x10) not accepted; then out_ready=1 → pops in order 0x00..0x0C, count=0 after 4 cycles.
- Latency: push pc 0x100, instr 0xFE010113 into empty queue at edge N → out_valid=0 before edge N, out_valid=1, out_pc=0x100, out_instr=0xFE010113 after it.
- Simultaneous push/pop with count=2 → count stays 2, ordering preserved; run 20 back-to-back cycles across pointer wrap with random out_ready, scoreboard matches FIFO order.
- Full + pop same cycle: count=4, in_valid=1, out_ready=1 → pop occurs, push refused, count=3.
- Flush: count=3, flush=1 with in_valid=1 and out_ready=1 → out_valid=0 and in_ready=0 that cycle, count=0 next cycle; next push pc 0x200 emerges first.

Source files
------------

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: circular FIFO of {pc, instr} pairs between fetch and
// decode. The oldest entry is presented to decode; flush drops everything.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready and out_valid depend only on the registered count and
// flush, never on in_valid/out_ready. While flush is high both are low, so
// nothing is pushed or popped that cycle.
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [31:0]   NOP_INSTR  = 32'h0000_0013;

  // Storage has no reset; only pointers and count define occupancy.
  logic [PC_W-1:0] r_mem_pc    [DEPTH];
  logic [31:0]     r_mem_instr [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_push;
  logic            w_pop;
  logic            w_in_ready;
  logic            w_out_valid;

  // Ready/valid come from registered count and flush only.
  always_comb begin
    w_in_ready  = (r_count != FULL_COUNT) && !flush;
    w_out_valid = (r_count != '0) && !flush;
    w_push      = in_valid && w_in_ready;
    w_pop       = w_out_valid && out_ready;
  end

  // Write the incoming pair into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= in_pc;
      r_mem_instr[r_wr_ptr] <= in_instr;
    end
  end

  // Pointers wrap naturally at DEPTH; flush empties the queue at the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry to decode; a NOP when nothing valid is presented.
  always_comb begin
    out_pc    = '0;
    out_instr = NOP_INSTR;
    if (w_out_valid) begin
      out_pc    = r_mem_pc[r_rd_ptr];
      out_instr = r_mem_instr[r_rd_ptr];
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign count     = r_count;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: directed vectors, expected pairs queued on
// accepted pushes, a negedge monitor comparing the head against the queue.
module tb_fetch_decode_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [PC_W-1:0] in_pc;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [CW-1:0]   count;

  int checks = 0;
  int errors = 0;

  logic [PC_W+31:0] exp_q[$];
  int m_count = 0;

  fetch_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Driver: apply inputs just after a rising edge, then advance one cycle.
  task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // Monitor and scoreboard: compare at negedge, then update the model.
  always @(negedge clk) begin
    logic exp_in_ready;
    logic exp_out_valid;
    logic do_push;
    logic do_pop;
    logic [PC_W+31:0] head;
    if (!rst_n) begin
      m_count = 0;
      exp_q.delete();
    end else begin
      exp_in_ready  = (m_count != DEPTH) && !flush;
      exp_out_valid = (m_count != 0) && !flush;
      chk("in_ready", 64'(in_ready), 64'(exp_in_ready));
      chk("out_valid", 64'(out_valid), 64'(exp_out_valid));
      chk("count", 64'(count), 64'(m_count));
      do_pop  = exp_out_valid && out_ready;
      do_push = in_valid && exp_in_ready;
      if (exp_out_valid && exp_q.size() > 0) begin
        head = exp_q[0];
        chk("head_pc", 64'(out_pc), 64'(head[PC_W+31:32]));
        chk("head_instr", 64'(out_instr), 64'(head[31:0]));
      end else if (!exp_out_valid) begin
        chk("nop_pc", 64'(out_pc), 64'h0);
        chk("nop_instr", 64'(out_instr), 64'h13);
      end
      if (flush) begin
        m_count = 0;
        exp_q.delete();
      end else begin
        if (do_pop && exp_q.size() > 0) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back({in_pc, in_instr});
        m_count = m_count + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
      end
    end
  end

  // Directed stimulus
  initial begin
    int pc_i;
    logic acc;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    rst_n     = 1'b0;
    #2;
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_instr", 64'(out_instr), 64'h13);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill to full with decode stalled
    for (int i = 0; i < 4; i++)
      drive(1'b1, 32'(i * 4), 32'h0050_0093 + 32'(i), 1'b0, 1'b0);
    chk("fill_count", 64'(count), 64'h4);
    chk("fill_in_ready", 64'(in_ready), 64'h0);
    drive(1'b1, 32'h10, 32'h0050_0097, 1'b0, 1'b0);
    chk("fifth_refused", 64'(count), 64'h4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", 64'(out_pc), 64'(i * 4));
      drive(1'b0, '0, '0, 1'b1, 1'b0);
    end
    chk("drain_count", 64'(count), 64'h0);

    // One-cycle latency, no bypass
    in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'hFE01_0113; out_ready = 1'b0;
    #1;
    chk("lat_before", 64'(out_valid), 64'h0);
    drive(1'b1, 32'h100, 32'hFE01_0113, 1'b0, 1'b0);
    chk("lat_valid", 64'(out_valid), 64'h1);
    chk("lat_pc", 64'(out_pc), 64'h100);
    chk("lat_instr", 64'(out_instr), 64'hFE01_0113);
    drive(1'b0, '0, '0, 1'b1, 1'b0);

    // Simultaneous push/pop at count 2, then back-to-back across wrap
    drive(1'b1, 32'h300, 32'h1111_0001, 1'b0, 1'b0);
    drive(1'b1, 32'h304, 32'h1111_0002, 1'b0, 1'b0);
    drive(1'b1, 32'h308, 32'h1111_0003, 1'b1, 1'b0);
    chk("pushpop_count", 64'(count), 64'h2);
    pc_i = 3;
    for (int i = 0; i < 20; i++) begin
      acc = (m_count != DEPTH);
      drive(1'b1, 32'h300 + 32'(pc_i * 4), 32'h1111_0000 + 32'(pc_i + 1),
            1'($urandom_range(0, 1)), 1'b0);
      if (acc) pc_i++;
    end
    for (int i = 0; i < 6; i++) drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("wrap_drained", 64'(count), 64'h0);

    // Full plus pop in the same cycle: pop only
    for (int i = 0; i < 4; i++)
      drive(1'b1, 32'h400 + 32'(i * 4), 32'h2222_0000 + 32'(i), 1'b0, 1'b0);
    drive(1'b1, 32'h410, 32'h2222_0004, 1'b1, 1'b0);
    chk("full_pop_count", 64'(count), 64'h3);

    // Flush with simultaneous push and pop
    in_valid = 1'b1; in_pc = 32'h500; in_instr = 32'h3333_0000; out_ready = 1'b1; flush = 1'b1;
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'h0);
    chk("flush_in_ready", 64'(in_ready), 64'h0);
    drive(1'b1, 32'h500, 32'h3333_0000, 1'b1, 1'b1);
    chk("flush_count", 64'(count), 64'h0);
    drive(1'b1, 32'h200, 32'h0000_0193, 1'b0, 1'b0);
    chk("post_flush_pc", 64'(out_pc), 64'h200);

    // Asynchronous reset with three entries held
    drive(1'b1, 32'h204, 32'h0000_0213, 1'b0, 1'b0);
    drive(1'b1, 32'h208, 32'h0000_0293, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("pre_reset_count", 64'(count), 64'h3);
    rst_n = 1'b0;
    #1;
    chk("areset_count", 64'(count), 64'h0);
    chk("areset_out_valid", 64'(out_valid), 64'h0);
    chk("areset_out_instr", 64'(out_instr), 64'h13);
    chk("areset_in_ready", 64'(in_ready), 64'h1);
    #6 rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 32'h600, 32'h4444_0000, 1'b0, 1'b0);
    chk("after_reset_pc", 64'(out_pc), 64'h600);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
